alu_pipe: RTL and testbench

Parametrised, two-stage pipelined integer ALU with valid/ready handshaking. It generalises the team's 32-bit combinational add/sub unit in four ways: configurable operand width, eight operations, a registered streaming interface with backpressure, and a sticky overflow status bit. It sits between an operand-issue stage and a writeback stage, so both neighbours stall on the handshake instead of sampling a combinational result.

---
 rtl/alu_pipe.sv | 143 ++++++++++++++
 tb/tb_alu_pipe.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined integer ALU with valid/ready handshaking on both sides.
// S1 holds operands; S2 holds the result and flags, and the outputs come straight from S2.
module alu_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_zero,
  output logic             out_negative,
  input  logic             clr_sticky,
  output logic             sticky_ovf
);

  typedef enum logic [2:0] {
    OpAdd   = 3'd0,
    OpSub   = 3'd1,
    OpAnd   = 3'd2,
    OpOr    = 3'd3,
    OpXor   = 3'd4,
    OpSlt   = 3'd5,
    OpSltu  = 3'd6,
    OpPassb = 3'd7
  } op_e;

  logic             r_s1_valid;
  op_e              r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_result;
  logic             r_s2_carry;
  logic             r_s2_ovf;
  logic             r_s2_zero;
  logic             r_s2_neg;
  logic             r_sticky;

  logic             w_s2_adv;
  logic             w_in_fire;
  logic             w_sub;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic             w_add_ovf;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_ovf;
  logic             w_sticky_set;

  // Ready is combinational from out_ready so a full pipe can accept while draining.
  assign w_s2_adv  = ~r_s2_valid | out_ready;
  assign in_ready  = ~r_s1_valid | w_s2_adv;
  assign w_in_fire = in_valid & in_ready;

  always_comb begin
    w_sub     = (r_s1_op == OpSub) | (r_s1_op == OpSlt) | (r_s1_op == OpSltu);
    w_b_eff   = r_s1_b ^ {WIDTH{w_sub}};
    w_sum     = {1'b0, r_s1_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
    w_add_ovf = (r_s1_a[WIDTH-1] == w_b_eff[WIDTH-1]) & (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);
    w_result  = '0;
    w_carry   = 1'b0;
    w_ovf     = 1'b0;
    unique case (r_s1_op)
      OpAdd, OpSub: begin
        w_result = w_sum[WIDTH-1:0];
        w_carry  = w_sum[WIDTH];
        w_ovf    = w_add_ovf;
      end
      OpAnd:   w_result = r_s1_a & r_s1_b;
      OpOr:    w_result = r_s1_a | r_s1_b;
      OpXor:   w_result = r_s1_a ^ r_s1_b;
      // Compares report only the boolean; the adder's carry/overflow stay internal.
      OpSlt:   w_result = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_add_ovf};
      OpSltu:  w_result = {{(WIDTH-1){1'b0}}, ~w_sum[WIDTH]};
      OpPassb: w_result = r_s1_b;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OpAdd;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_op    <= op_e'(in_op);
      r_s1_a     <= in_a;
      r_s1_b     <= in_b;
    end else if (w_s2_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_carry  <= 1'b0;
      r_s2_ovf    <= 1'b0;
      r_s2_zero   <= 1'b0;
      r_s2_neg    <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_result <= w_result;
        r_s2_carry  <= w_carry;
        r_s2_ovf    <= w_ovf;
        r_s2_zero   <= (w_result == '0);
        r_s2_neg    <= w_result[WIDTH-1];
      end
    end
  end

  // Set beats clear when both happen on the same edge.
  assign w_sticky_set = r_s2_valid & out_ready & r_s2_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else begin
      r_sticky <= w_sticky_set | (r_sticky & ~clr_sticky);
    end
  end

  assign out_valid    = r_s2_valid;
  assign out_result   = r_s2_result;
  assign out_carry    = r_s2_carry;
  assign out_overflow = r_s2_ovf;
  assign out_zero     = r_s2_zero;
  assign out_negative = r_s2_neg;
  assign sticky_ovf   = r_sticky;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vectors with literal expectations plus an arithmetic
// reference model and a scoreboard checked on every clock at the falling edge.
module tb_alu_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_carry, out_overflow, out_zero, out_negative;
  logic        clr_sticky, sticky_ovf;

  logic        in_valid8, in_ready8;
  logic [2:0]  in_op8;
  logic [7:0]  in_a8, in_b8;
  logic        out_valid8, out_ready8;
  logic [7:0]  out_result8;
  logic        out_carry8, out_overflow8, out_zero8, out_negative8;
  logic        clr_sticky8, sticky_ovf8;

  int checks = 0;
  int failures = 0;

  alu_pipe #(.WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_overflow(out_overflow), .out_zero(out_zero),
    .out_negative(out_negative), .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf)
  );

  alu_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_op(in_op8), .in_a(in_a8), .in_b(in_b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_result(out_result8),
    .out_carry(out_carry8), .out_overflow(out_overflow8), .out_zero(out_zero8),
    .out_negative(out_negative8), .clr_sticky(clr_sticky8), .sticky_ovf(sticky_ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        v;
  } exp_t;

  // Reference: plain signed/unsigned arithmetic on 64-bit integers.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, ua, ub, s;
    longint maxs, mins;
    maxs = 64'sh7FFF_FFFF;
    mins = -64'sh8000_0000;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    e = '0;
    case (op)
      3'd0: begin
        e.res = a + b;
        e.c   = (ua + ub) > 64'hFFFF_FFFF;
        s     = sa + sb;
        e.v   = (s > maxs) || (s < mins);
      end
      3'd1: begin
        e.res = a - b;
        e.c   = (ua >= ub);
        s     = sa - sb;
        e.v   = (s > maxs) || (s < mins);
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: e.res = (sa < sb) ? 32'd1 : 32'd0;
      3'd6: e.res = (ua < ub) ? 32'd1 : 32'd0;
      default: e.res = b;
    endcase
    return e;
  endfunction

  exp_t        q[$];
  logic        m_sticky;
  logic        prev_stall;
  logic [35:0] prev_snap;

  // Scoreboard: inputs change only just after rising edges, so the falling edge sees
  // exactly what the next rising edge will act on.
  always @(negedge clk) begin
    exp_t e;
    logic xfer_ovf;
    if (!rst_n) begin
      q.delete();
      m_sticky   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      xfer_ovf = 1'b0;
      chk("sticky_model", sticky_ovf, m_sticky);
      if (prev_stall)
        chk("stall_hold", {out_result, out_carry, out_overflow, out_zero, out_negative}, prev_snap);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_output", 1'b1, 1'b0);
        end else begin
          e = q.pop_front();
          chk("sb_result", out_result, e.res);
          chk("sb_carry", out_carry, e.c);
          chk("sb_overflow", out_overflow, e.v);
          chk("sb_zero", out_zero, e.res == 32'd0);
          chk("sb_negative", out_negative, e.res[31]);
          xfer_ovf = e.v;
        end
      end
      if (xfer_ovf) m_sticky = 1'b1;
      else if (clr_sticky) m_sticky = 1'b0;
      if (in_valid && in_ready) q.push_back(model(in_op, in_a, in_b));
      prev_stall = out_valid & ~out_ready;
      prev_snap  = {out_result, out_carry, out_overflow, out_zero, out_negative};
    end
  end

  // Presents one operand set and returns just after the edge that accepts it.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 1'b1, 1'b0);
    in_valid = 1'b0;
  endtask

  task automatic single(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic c,
                        input logic v);
    send(op, a, b);
    @(posedge clk);
    #1;
    chk({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_result"}, out_result, res);
    chk({name, "_carry"}, out_carry, c);
    chk({name, "_ovf"}, out_overflow, v);
    chk({name, "_zero"}, out_zero, res == 32'd0);
    chk({name, "_neg"}, out_negative, res[31]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    out_ready = 1'b1; clr_sticky = 1'b0;
    in_valid8 = 1'b0; in_op8 = '0; in_a8 = '0; in_b8 = '0;
    out_ready8 = 1'b1; clr_sticky8 = 1'b0;

    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_result", out_result, 32'h0);
    chk("rst_sticky", sticky_ovf, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Add overflow with latency and sticky update
    send(3'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    chk("add_latency_early", out_valid, 1'b0);
    @(posedge clk);
    #1;
    chk("add_valid", out_valid, 1'b1);
    chk("add_result", out_result, 32'h8000_0000);
    chk("add_ovf", out_overflow, 1'b1);
    chk("add_carry", out_carry, 1'b0);
    chk("add_neg", out_negative, 1'b1);
    chk("add_zero", out_zero, 1'b0);
    @(posedge clk);
    #1;
    chk("add_sticky", sticky_ovf, 1'b1);

    single("sub_eq", 3'd1, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0);
    single("sub_borrow", 3'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    single("slt_neg", 3'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    single("sltu_big", 3'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0);
    single("slt_ovf", 3'd5, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    single("and", 3'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0);
    single("or", 3'd3, 32'hF000_0001, 32'h0000_0010, 32'hF000_0011, 1'b0, 1'b0);
    single("xor", 3'd4, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0, 1'b0, 1'b0);
    single("passb", 3'd7, 32'h1234_5678, 32'h8765_4321, 32'h8765_4321, 1'b0, 1'b0);

    // Backpressure: two accepts fill the pipe, then it stalls and holds
    out_ready = 1'b0;
    send(3'd0, 32'd0, 32'd100);
    send(3'd0, 32'd1, 32'd100);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready_low", in_ready, 1'b0);
      chk("bp_hold_result", out_result, 32'd100);
      chk("bp_hold_valid", out_valid, 1'b1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    fork
      begin
        send(3'd0, 32'd2, 32'd100);
        send(3'd0, 32'd3, 32'd100);
      end
      begin
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("bp_order_valid", out_valid, 1'b1);
          chk("bp_order_result", out_result, 32'd100 + 32'(k));
        end
      end
    join
    @(posedge clk);
    #1;
    chk("bp_drained", out_valid, 1'b0);

    // Sticky: clear alone, then set and clear together, then clear alone
    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
    chk("sticky_cleared", sticky_ovf, 1'b0);
    out_ready = 1'b0;
    send(3'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    chk("sticky_set_wins", sticky_ovf, 1'b1);
    @(posedge clk);
    #1;
    chk("sticky_clear_next", sticky_ovf, 1'b0);
    clr_sticky = 1'b0;

    // Reset mid-stream with sticky set and both stages full
    send(3'd1, 32'h8000_0000, 32'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("pre_rst_sticky", sticky_ovf, 1'b1);
    out_ready = 1'b0;
    send(3'd0, 32'd10, 32'd20);
    send(3'd0, 32'd30, 32'd40);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_result", out_result, 32'h0);
    chk("midrst_sticky", sticky_ovf, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("postrst_in_ready", in_ready, 1'b1);
    single("postrst_add", 3'd0, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);

    // WIDTH=8 variant
    chk("w8_in_ready", in_ready8, 1'b1);
    in_valid8 = 1'b1; in_op8 = 3'd0; in_a8 = 8'hFF; in_b8 = 8'h01;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    @(posedge clk);
    #1;
    chk("w8_valid", out_valid8, 1'b1);
    chk("w8_result", out_result8, 8'h00);
    chk("w8_carry", out_carry8, 1'b1);
    chk("w8_zero", out_zero8, 1'b1);
    chk("w8_ovf", out_overflow8, 1'b0);
    @(posedge clk);
    #1;

    chk("sb_queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
